// File: rtl/inert_pkg.sv
// Shared types and constants for the pitch interface: sequencer states,
// IMU command words and fusion arithmetic constants.
package inert_pkg;

  typedef enum logic [3:0] {
    INIT_WAIT,
    INIT1,
    INIT2,
    INIT3,
    INIT4,
    IDLE,
    RD_PL,
    RD_PH,
    RD_AL,
    RD_AH
  } state_t;

  // IMU configuration writes, issued in order after the power-up timer
  localparam logic [15:0] INIT_CMD0 = 16'h0D02;
  localparam logic [15:0] INIT_CMD1 = 16'h1053;
  localparam logic [15:0] INIT_CMD2 = 16'h1150;
  localparam logic [15:0] INIT_CMD3 = 16'h1460;

  // Register reads for one data-ready service
  localparam logic [15:0] RD_PTCHL = 16'hA200;
  localparam logic [15:0] RD_PTCHH = 16'hA300;
  localparam logic [15:0] RD_AZL   = 16'hAC00;
  localparam logic [15:0] RD_AZH   = 16'hAD00;

  // Complementary-filter constants
  localparam int FUSION_STEP = 1024;
  localparam int ACC_GAIN    = 327;

endpackage

// File: rtl/inertial_integrator.sv
// Fusion integrator: turns the four captured IMU bytes into a bias-corrected
// pitch rate and an integrated pitch, nudged toward the accelerometer
// estimate by a fixed step each sample. vld marks the cycle outputs refresh.
module inertial_integrator
  import inert_pkg::*;
#(
  parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
  parameter logic [15:0] AZ_OFFSET      = 16'h00A0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd,
  input  logic [7:0]  pitch_l,
  input  logic [7:0]  pitch_h,
  input  logic [7:0]  az_l,
  input  logic [7:0]  az_h,
  output logic [15:0] ptch,
  output logic [15:0] ptch_rt,
  output logic        vld
);

  logic [15:0]        rt_c;
  logic [15:0]        az_c;
  logic signed [25:0] acc_prod;
  logic signed [15:0] ptch_acc;
  logic [26:0]        fusion;
  logic [26:0]        ptch_int;
  logic [26:0]        ptch_int_nxt;

  // Sample arithmetic: bias removal, accel-derived pitch and next integrator value
  always_comb begin
    rt_c     = {pitch_h, pitch_l} - PTCH_RT_OFFSET;
    az_c     = {az_h, az_l} - AZ_OFFSET;
    acc_prod = $signed({{10{az_c[15]}}, az_c}) * $signed(26'(ACC_GAIN));
    // arithmetic shift then truncate == sign-extended acc_prod[25:13]
    ptch_acc = 16'(acc_prod >>> 13);
    fusion   = (ptch_acc > $signed(ptch)) ? 27'(FUSION_STEP) : 27'(-FUSION_STEP);
    ptch_int_nxt = ptch_int - {{11{rt_c[15]}}, rt_c} + fusion;
  end

  // Integrator and output registers; ptch loads from the new integrator value
  // so ptch, ptch_rt and vld all change on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch_int <= '0;
      ptch     <= '0;
      ptch_rt  <= '0;
      vld      <= 1'b0;
    end else begin
      vld <= upd;
      if (upd) begin
        ptch_int <= ptch_int_nxt;
        ptch     <= ptch_int_nxt[26:11];
        ptch_rt  <= rt_c;
      end
    end
  end

endmodule

// File: rtl/inert_intf.sv
// IMU producer for the balance controller: configures the IMU over the SPI
// master after a power-up delay, then reads pitch rate and Z-accel on each
// data-ready interrupt and hands the bytes to the fusion integrator.
module inert_intf
  import inert_pkg::*;
#(
  parameter bit          FAST_SIM       = 1'b1,
  parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
  parameter logic [15:0] AZ_OFFSET      = 16'h00A0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch,
  output logic [15:0] ptch_rt,
  output logic        vld
);

  localparam logic [15:0] TIMER_TC = FAST_SIM ? 16'h03FF : 16'hFFFF;

  state_t      state, state_nxt;
  logic        int_s1, int_sync;
  logic [15:0] timer;
  logic        wrt_nxt;
  logic [15:0] cmd_nxt;
  logic        take;
  logic [7:0]  pitch_l, pitch_h, az_l, az_h;
  logic        upd;

  // A done arriving while wrt is still high cannot belong to the command
  // just issued, so it is not accepted as a completion
  assign take = done && !wrt;

  // Two-flop synchronizer for the asynchronous data-ready line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_s1   <= 1'b0;
      int_sync <= 1'b0;
    end else begin
      int_s1   <= INT;
      int_sync <= int_s1;
    end
  end

  // Power-up delay timer, runs only while waiting to configure the IMU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  timer <= '0;
    else if (state == INIT_WAIT) timer <= timer + 16'd1;
    else                         timer <= '0;
  end

  // Sequencer state and registered SPI command outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_WAIT;
      wrt   <= 1'b0;
      cmd   <= '0;
    end else begin
      state <= state_nxt;
      wrt   <= wrt_nxt;
      cmd   <= cmd_nxt;
    end
  end

  // Next-state and command selection
  always_comb begin
    state_nxt = state;
    wrt_nxt   = 1'b0;
    cmd_nxt   = cmd;
    unique case (state)
      INIT_WAIT: if (timer == TIMER_TC) begin
        wrt_nxt = 1'b1; cmd_nxt = INIT_CMD0; state_nxt = INIT1;
      end
      INIT1: if (take) begin
        wrt_nxt = 1'b1; cmd_nxt = INIT_CMD1; state_nxt = INIT2;
      end
      INIT2: if (take) begin
        wrt_nxt = 1'b1; cmd_nxt = INIT_CMD2; state_nxt = INIT3;
      end
      INIT3: if (take) begin
        wrt_nxt = 1'b1; cmd_nxt = INIT_CMD3; state_nxt = INIT4;
      end
      INIT4: if (take) state_nxt = IDLE;
      IDLE: if (int_sync) begin
        wrt_nxt = 1'b1; cmd_nxt = RD_PTCHL; state_nxt = RD_PL;
      end
      RD_PL: if (take) begin
        wrt_nxt = 1'b1; cmd_nxt = RD_PTCHH; state_nxt = RD_PH;
      end
      RD_PH: if (take) begin
        wrt_nxt = 1'b1; cmd_nxt = RD_AZL; state_nxt = RD_AL;
      end
      RD_AL: if (take) begin
        wrt_nxt = 1'b1; cmd_nxt = RD_AZH; state_nxt = RD_AH;
      end
      RD_AH: if (take) state_nxt = IDLE;
      default: state_nxt = INIT_WAIT;
    endcase
  end

  // Capture the low byte of each read and flag a complete sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pitch_l <= '0;
      pitch_h <= '0;
      az_l    <= '0;
      az_h    <= '0;
      upd     <= 1'b0;
    end else begin
      upd <= take && (state == RD_AH);
      if (take) begin
        case (state)
          RD_PL:   pitch_l <= rd_data[7:0];
          RD_PH:   pitch_h <= rd_data[7:0];
          RD_AL:   az_l    <= rd_data[7:0];
          RD_AH:   az_h    <= rd_data[7:0];
          default: ;
        endcase
      end
    end
  end

  inertial_integrator #(
    .PTCH_RT_OFFSET (PTCH_RT_OFFSET),
    .AZ_OFFSET      (AZ_OFFSET)
  ) u_integrator (
    .clk     (clk),
    .rst_n   (rst_n),
    .upd     (upd),
    .pitch_l (pitch_l),
    .pitch_h (pitch_h),
    .az_l    (az_l),
    .az_h    (az_h),
    .ptch    (ptch),
    .ptch_rt (ptch_rt),
    .vld     (vld)
  );

endmodule

// File: tb/tb_inert_intf.sv
// Directed bench for inert_intf: init sequence timing, table of read chains
// with hand-computed fusion results, a long constant-rate run against an
// integer model, spurious done/INT activity, back-to-back chains and a
// mid-chain reset.
module tb_inert_intf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] ptch;
  logic [15:0] ptch_rt;
  logic        vld;

  int n_chk  = 0;
  int n_fail = 0;
  int wrt_cnt = 0;
  int vld_cnt = 0;
  int pint;

  always #5 clk = ~clk;

  inert_intf #(
    .FAST_SIM       (1'b1),
    .PTCH_RT_OFFSET (16'h0050),
    .AZ_OFFSET      (16'h00A0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .INT     (INT),
    .done    (done),
    .rd_data (rd_data),
    .wrt     (wrt),
    .cmd     (cmd),
    .ptch    (ptch),
    .ptch_rt (ptch_rt),
    .vld     (vld)
  );

  // pulse counters, sampled well after the falling edge
  always begin
    @(negedge clk);
    #2;
    if (wrt) wrt_cnt++;
    if (vld) vld_cnt++;
  end

  typedef struct {
    logic [7:0]  pl, ph, al, ah;
    logic [15:0] rt, pt;
  } vec_t;

  logic [15:0] rd_cmds [4];
  logic [15:0] ini_cmds [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_wrt(input string name, output bit got);
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (wrt) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) chk({name, "_timeout"}, 32'(got), 32'd1);
  endtask

  function automatic logic [15:0] model_ptch(input int p);
    int t;
    t = p >>> 11;
    return t[15:0];
  endfunction

  function automatic int model_step(input int p, input logic [15:0] rt, input logic signed [15:0] pacc);
    logic signed [15:0] cur;
    cur = model_ptch(p);
    return p - int'($signed(rt)) + ((pacc > cur) ? 1024 : -1024);
  endfunction

  // Reset release to IDLE: timing of the first write, write sequence, idle quiet
  task automatic run_init(input string tag);
    int cnt;
    int w0;
    bit got;
    cnt = 0;
    while (!wrt && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_first_wrt_clk"}, 32'(cnt), 32'd1024);
    for (int unsigned k = 0; k < 4; k++) begin
      wait_wrt($sformatf("%s_init_wrt%0d", tag, k), got);
      chk($sformatf("%s_init_cmd%0d", tag, k), 32'(cmd), 32'(ini_cmds[k]));
      repeat (20) @(negedge clk);
      done = 1'b1; rd_data = 16'h0000;
      @(negedge clk);
      done = 1'b0;
    end
    w0 = wrt_cnt;
    repeat (10) @(negedge clk);
    // stray done in IDLE with INT low must not start anything
    done = 1'b1; rd_data = 16'h1234;
    @(negedge clk);
    done = 1'b0;
    repeat (100) @(negedge clk);
    chk({tag, "_idle_no_wrt"}, 32'(wrt_cnt - w0), 32'd0);
  endtask

  // One read chain; stop_k < 4 abandons it after that command is seen
  task automatic run_chain(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input bit spur, input bit hold, input int stop_k,
                           input logic [15:0] exp_rt, input logic [15:0] exp_pt);
    logic [7:0] b [4];
    bit got;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    INT = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_wrt($sformatf("%s_wrt%0d", tag, k), got);
      if (!got) return;
      chk($sformatf("%s_cmd%0d", tag, k), 32'(cmd), 32'(rd_cmds[k]));
      if (k == 0 && !hold) INT = 1'b0;
      if (k == stop_k) begin
        repeat (5) @(negedge clk);
        return;
      end
      if (spur && k == 0) begin
        done = 1'b1; rd_data = 16'hFFFF;
        @(negedge clk);
        done = 1'b0;
        repeat (18) @(negedge clk);
      end else begin
        if (spur && k == 1) INT = 1'b1;
        if (spur && k == 2) INT = 1'b0;
        repeat (19) @(negedge clk);
      end
      rd_data = {8'hC3, b[k]}; done = 1'b1;
      @(negedge clk);
      done = 1'b0; rd_data = '0;
      if (k == 3) begin
        chk({tag, "_vld_early"}, 32'(vld), 32'd0);
        @(negedge clk);
        chk({tag, "_vld"}, 32'(vld), 32'd1);
        chk({tag, "_ptch_rt"}, 32'(ptch_rt), 32'(exp_rt));
        chk({tag, "_ptch"}, 32'(ptch), 32'(exp_pt));
        if (hold) begin
          chk({tag, "_b2b_wrt"}, 32'(wrt), 32'd1);
          chk({tag, "_b2b_cmd"}, 32'(cmd), 32'h0000A200);
        end else begin
          chk({tag, "_no_wrt"}, 32'(wrt), 32'd0);
        end
      end
    end
  endtask

  initial begin
    vec_t tbl [6];
    int w0, v0;

    rd_cmds[0] = 16'hA200; rd_cmds[1] = 16'hA300;
    rd_cmds[2] = 16'hAC00; rd_cmds[3] = 16'hAD00;
    ini_cmds[0] = 16'h0D02; ini_cmds[1] = 16'h1053;
    ini_cmds[2] = 16'h1150; ini_cmds[3] = 16'h1460;

    // pl, ph, al, ah, expected ptch_rt, expected ptch (chained from reset)
    tbl[0] = '{8'h50, 8'h00, 8'hA0, 8'h00, 16'h0000, 16'hFFFF};
    tbl[1] = '{8'h50, 8'h04, 8'hA0, 8'h10, 16'h0400, 16'hFFFF};
    tbl[2] = '{8'h50, 8'hF8, 8'hA0, 8'hF0, 16'hF800, 16'h0000};
    tbl[3] = '{8'h50, 8'hE0, 8'hA0, 8'h00, 16'hE000, 16'h0003};
    tbl[4] = '{8'h50, 8'h10, 8'hA0, 8'h70, 16'h1000, 16'h0002};
    tbl[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 16'hFFB0, 16'h0001};

    rst_n = 1'b0; INT = 1'b0; done = 1'b0; rd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_wrt", 32'(wrt), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_ptch", 32'(ptch), 32'd0);
    chk("rst_ptch_rt", 32'(ptch_rt), 32'd0);
    chk("rst_vld", 32'(vld), 32'd0);
    rst_n = 1'b1;

    run_init("init");

    foreach (tbl[i])
      run_chain($sformatf("tbl%0d", i), tbl[i].pl, tbl[i].ph, tbl[i].al, tbl[i].ah,
                1'b0, 1'b0, 4, tbl[i].rt, tbl[i].pt);

    // integrator state left by the table: 3152
    pint = 3152;
    for (int i = 0; i < 100; i++) begin
      pint = model_step(pint, 16'h0010, 16'sd0);
      run_chain($sformatf("rate%0d", i), 8'h60, 8'h00, 8'hA0, 8'h00,
                1'b0, 1'b0, 4, 16'h0010, model_ptch(pint));
      repeat (3) @(negedge clk);
    end

    for (int i = 0; i < 2; i++) begin
      repeat (5) @(negedge clk);
      w0 = wrt_cnt; v0 = vld_cnt;
      pint = model_step(pint, 16'h0010, 16'sd0);
      run_chain($sformatf("spur%0d", i), 8'h60, 8'h00, 8'hA0, 8'h00,
                1'b1, 1'b0, 4, 16'h0010, model_ptch(pint));
      repeat (30) @(negedge clk);
      chk($sformatf("spur%0d_wrt_count", i), 32'(wrt_cnt - w0), 32'd4);
      chk($sformatf("spur%0d_vld_count", i), 32'(vld_cnt - v0), 32'd1);
    end

    for (int i = 0; i < 3; i++) begin
      pint = model_step(pint, 16'h0010, 16'sd0);
      run_chain($sformatf("b2b%0d", i), 8'h60, 8'h00, 8'hA0, 8'h00,
                1'b0, (i < 2), 4, 16'h0010, model_ptch(pint));
    end
    repeat (20) @(negedge clk);

    // reset while waiting for the AZ low read
    run_chain("abort", 8'h60, 8'h00, 8'hA0, 8'h00, 1'b0, 1'b0, 2, 16'h0000, 16'h0000);
    v0 = vld_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_rst_wrt", 32'(wrt), 32'd0);
    chk("abort_rst_cmd", 32'(cmd), 32'd0);
    chk("abort_rst_ptch", 32'(ptch), 32'd0);
    chk("abort_rst_ptch_rt", 32'(ptch_rt), 32'd0);
    chk("abort_rst_vld", 32'(vld), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_init("reinit");
    chk("reinit_no_vld", 32'(vld_cnt - v0), 32'd0);
    chk("reinit_ptch", 32'(ptch), 32'd0);
    chk("reinit_ptch_rt", 32'(ptch_rt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inert_intf.md
Name: inert_intf

Overview:
Producer side of the balance controller's pitch interface. It configures the IMU over an external SPI master, then services each IMU data-ready interrupt by reading the pitch-rate and Z-acceleration registers. A fusion integrator turns those readings into the ptch, ptch_rt and vld signals consumed by the PID block. The block sits between the SPI master (command/done handshake) and the PID controller.

Parameters:
FAST_SIM, 1, 1: init timer terminal count 2^10 clk; 0: 2^16 clk
PTCH_RT_OFFSET, 16'h0050, gyro zero-rate bias subtracted from raw rate
AZ_OFFSET, 16'h00A0, accel bias subtracted from raw Z-accel

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
INT  in  1  IMU data-ready, asynchronous to clk
done  in  1  SPI master transaction complete, 1-clk pulse
rd_data  in  16  SPI read data; low byte valid when done=1
wrt  out  1  start SPI transaction, 1-clk pulse
cmd  out  16  SPI command word, held stable from wrt until done
ptch  out  16  signed fused pitch
ptch_rt  out  16  signed bias-compensated pitch rate
vld  out  1  1-clk pulse; ptch/ptch_rt fresh

Behaviour:
- Reset state: all outputs 0; state INIT_WAIT; timer 0; integrator 0; holding bytes 0.
- INT is passed through a 2-flop synchronizer. Only the synchronized level is used.
- INIT_WAIT: a free-running timer counts to its terminal value (all ones for the selected width).
  - At terminal count: issue wrt with cmd 16'h0D02, then go to INIT1.
- INIT1..INIT4: each state waits for done, then issues the next write.
  - Write sequence after 16'h0D02: 16'h1053, 16'h1150, 16'h1460.
  - done in INIT4 goes to IDLE.
- IDLE: when synchronized INT=1, issue wrt with cmd 16'hA200 and go to RD_PL.
- Read chain on each done: capture rd_data[7:0] into the byte for that state, issue the next wrt the same cycle, and advance state.
  - RD_PL captures pitchL, then issues cmd 16'hA300.
  - RD_PH captures pitchH, then issues cmd 16'hAC00.
  - RD_AL captures azL, then issues cmd 16'hAD00.
  - RD_AH captures azH, pulses upd, and returns to IDLE.
- INT is sampled only in IDLE; INT activity during the init or read chain is ignored.
- If INT is still high on return to IDLE, the next read chain starts immediately.
- done with no transaction outstanding (IDLE or INIT_WAIT) is ignored.
- wrt is never asserted in the same cycle as an outstanding transaction's done unless the chain itself issues the next command.
- Integrator (on upd only):
  - rt_c = {pitchH,pitchL} - PTCH_RT_OFFSET (16-bit, wraps).
  - az_c = {azH,azL} - AZ_OFFSET.
  - acc_prod = signed(az_c) * 327 (26 bits).
  - ptch_acc = sign-extended acc_prod[25:13] (16 bits).
  - fusion = +1024 if ptch_acc > ptch, else -1024.
  - ptch_int (27-bit signed) <= ptch_int - sext(rt_c) + fusion. Wraps; no saturation.
  - ptch_rt <= rt_c.
- ptch = ptch_int[26:11], registered.
- vld = upd delayed 1 clk. ptch and ptch_rt therefore reflect the new sample in the vld cycle and hold until the next vld.
- Latency: last done to vld is 2 clk.
- rst_n asserted mid-chain: immediate return to INIT_WAIT, integrator cleared, full re-init required.

Decomposition:
- Shared package inert_pkg holds:
  - state enum type;
  - init command constants (INIT_CMD0..3);
  - read command constants (RD_PTCHL/H, RD_AZL/H);
  - FUSION_STEP=1024 and ACC_GAIN=327.
- One sub-module, inertial_integrator, contains the byte-to-ptch arithmetic, the ptch/ptch_rt registers and the vld delay. Its inputs are upd and the four bytes.
- The top level holds the synchronizer, timer and sequencer FSM.

Test Plan:
- Reset release, FAST_SIM=1, SPI model returns done 20 clk after each wrt -> wrt #1 at clk 1024 with cmd 16'h0D02; subsequent cmds 16'h1053, 16'h1150, 16'h1460; then IDLE with no further wrt.
- INT high after init, rd_data low bytes 0x50,0x00,0xA0,0x00 -> cmds A200/A300/AC00/AD00 in order; vld 2 clk after 4th done; ptch_rt=0; ptch_int=-1024, so ptch=-1.
- Rate bytes 0x50+0x10, 0x00 (rt_c=16), az bias only, 100 samples -> ptch_rt=16 each vld; ptch_int changes by -16 plus the fusion step (+1024 when ptch<0, else -1024) each sample.
- INT toggled and spurious done pulses during the read chain -> no extra wrt, exactly one vld per chain.
- INT held high continuously -> back-to-back chains, with wrt A200 in the cycle after the return to IDLE.
- rst_n pulsed during RD_AL -> outputs 0 and no vld; cmd 16'h0D02 reissued 1024 clk after release.
